wide_mac_stream: RTL and testbench

Streaming, pipelined multiply-accumulate for the histogram datapath. It multiplies two independently signed or unsigned operands and sums the products over a group of beats ended by s_last. For each group it emits one accumulated result with an overflow flag. All stages share one clock-enable, so the block fully supports valid/ready backpressure.

---
 rtl/wide_mac_stream.sv | 170 +++++++++++++++++
 tb/tb_wide_mac_stream.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wide_mac_stream.sv
// Pipelined streaming multiply-accumulate: sums A*B over each s_last-terminated group
// and emits one result per group with a sticky overflow flag, under valid/ready flow control.
module wide_mac_stream #(
    parameter int A_WIDTH      = 24,
    parameter int A_UNSIGNED   = 1,
    parameter int B_WIDTH      = 34,
    parameter int B_UNSIGNED   = 1,
    parameter int ACC_WIDTH    = 64,
    parameter int OUT_WIDTH    = ACC_WIDTH,
    parameter int MULT_LATENCY = 4,
    parameter int SATURATE     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [A_WIDTH-1:0]   s_a,
    input  logic [B_WIDTH-1:0]   s_b,
    input  logic                 s_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 m_overflow
);

    localparam int MW         = A_WIDTH + B_WIDTH;
    localparam bit RES_SIGNED = (A_UNSIGNED == 0) || (B_UNSIGNED == 0);
    localparam int L          = MULT_LATENCY;

    if (A_UNSIGNED != 0 && A_UNSIGNED != 1) begin : g_chk_a
        $fatal(1, "wide_mac_stream: A_UNSIGNED must be 0 or 1");
    end
    if (B_UNSIGNED != 0 && B_UNSIGNED != 1) begin : g_chk_b
        $fatal(1, "wide_mac_stream: B_UNSIGNED must be 0 or 1");
    end
    if (ACC_WIDTH < MW) begin : g_chk_acc
        $fatal(1, "wide_mac_stream: ACC_WIDTH must be >= A_WIDTH+B_WIDTH");
    end
    if (OUT_WIDTH > ACC_WIDTH || OUT_WIDTH < 1) begin : g_chk_out
        $fatal(1, "wide_mac_stream: OUT_WIDTH must be in 1..ACC_WIDTH");
    end
    if (MULT_LATENCY < 2) begin : g_chk_lat
        $fatal(1, "wide_mac_stream: MULT_LATENCY must be >= 2");
    end

    logic                 w_ce;
    logic                 w_a_sign;
    logic                 w_b_sign;
    logic                 r_in_valid;
    logic                 r_in_last;
    logic [MW-1:0]        r_a;
    logic [MW-1:0]        r_b;
    logic [MW-1:0]        r_prod [L];
    logic [L-1:0]         r_pv;
    logic [L-1:0]         r_pl;
    logic [ACC_WIDTH-1:0] w_prod_ext;
    logic [ACC_WIDTH-1:0] w_base;
    logic [ACC_WIDTH-1:0] w_sum;
    logic [ACC_WIDTH-1:0] w_acc_next;
    logic                 w_carry;
    logic                 w_ovf;
    logic                 w_sticky_next;
    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_first;
    logic                 r_sticky;
    logic                 r_m_valid;
    logic [OUT_WIDTH-1:0] r_m_data;
    logic                 r_m_ovf;

    assign w_ce       = !r_m_valid || m_ready;
    assign s_ready    = w_ce;
    assign m_valid    = r_m_valid;
    assign m_data     = r_m_data;
    assign m_overflow = r_m_ovf;

    // Operands are pre-extended to the full product width so a plain MW x MW
    // multiply truncated to MW bits yields the correct product for any signedness.
    assign w_a_sign = (A_UNSIGNED == 0) ? s_a[A_WIDTH-1] : 1'b0;
    assign w_b_sign = (B_UNSIGNED == 0) ? s_b[B_WIDTH-1] : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_valid <= 1'b0;
            r_in_last  <= 1'b0;
        end else if (w_ce) begin
            r_in_valid <= s_valid;
            r_in_last  <= s_valid && s_last;
        end
    end

    always_ff @(posedge clk) begin
        if (w_ce) begin
            r_a <= {{B_WIDTH{w_a_sign}}, s_a};
            r_b <= {{A_WIDTH{w_b_sign}}, s_b};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pv <= '0;
            r_pl <= '0;
        end else if (w_ce) begin
            r_pv <= {r_pv[L-2:0], r_in_valid};
            r_pl <= {r_pl[L-2:0], r_in_last};
        end
    end

    always_ff @(posedge clk) begin
        if (w_ce) begin
            r_prod[0] <= r_a * r_b;
            for (int unsigned i = 1; i < L; i++) begin
                r_prod[i] <= r_prod[i-1];
            end
        end
    end

    if (ACC_WIDTH > MW) begin : g_ext
        logic w_psign;
        assign w_psign    = RES_SIGNED ? r_prod[L-1][MW-1] : 1'b0;
        assign w_prod_ext = {{(ACC_WIDTH-MW){w_psign}}, r_prod[L-1]};
    end else begin : g_noext
        assign w_prod_ext = r_prod[L-1];
    end

    always_comb begin
        w_base             = r_first ? '0 : r_acc;
        {w_carry, w_sum}   = {1'b0, w_base} + {1'b0, w_prod_ext};
        w_acc_next         = w_sum;
        w_ovf              = 1'b0;
        if (RES_SIGNED) begin
            if (w_base[ACC_WIDTH-1] == w_prod_ext[ACC_WIDTH-1] &&
                w_sum[ACC_WIDTH-1] != w_base[ACC_WIDTH-1]) begin
                w_ovf = 1'b1;
                if (SATURATE != 0) begin
                    w_acc_next = w_base[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                                     : {1'b0, {(ACC_WIDTH-1){1'b1}}};
                end
            end
        end else if (w_carry) begin
            w_ovf = 1'b1;
            if (SATURATE != 0) begin
                w_acc_next = '1;
            end
        end
        w_sticky_next = (!r_first && r_sticky) || w_ovf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_first   <= 1'b1;
            r_sticky  <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_ovf   <= 1'b0;
        end else if (w_ce) begin
            r_m_valid <= r_pv[L-1] && r_pl[L-1];
            if (r_pv[L-1]) begin
                r_acc    <= w_acc_next;
                r_sticky <= w_sticky_next;
                r_first  <= r_pl[L-1];
                if (r_pl[L-1]) begin
                    r_m_data <= w_acc_next[ACC_WIDTH-1 -: OUT_WIDTH];
                    r_m_ovf  <= w_sticky_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_wide_mac_stream.sv
// Directed bench for wide_mac_stream: default, signed-A, and 8x8/16 saturating and wrapping
// instances share one input stream; table-driven groups plus timing, stall and reset sequences.
module tb_wide_mac_stream;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic        s_last;
    logic        m_ready;
    logic [23:0] s_a24;
    logic [33:0] s_b34;
    logic [7:0]  s_a8;
    logic [7:0]  s_b8;

    logic        ready0, ready1, ready2, ready3;
    logic        mv0, mv1, mv2, mv3;
    logic [63:0] md0, md1;
    logic [15:0] md2, md3;
    logic        mo0, mo1, mo2, mo3;

    int n_pass  = 0;
    int n_total = 0;

    wide_mac_stream dut0 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(ready0), .s_a(s_a24), .s_b(s_b34),
        .s_last(s_last), .m_valid(mv0), .m_ready(m_ready), .m_data(md0), .m_overflow(mo0)
    );

    wide_mac_stream #(.A_UNSIGNED(0)) dut1 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(ready1), .s_a(s_a24), .s_b(s_b34),
        .s_last(s_last), .m_valid(mv1), .m_ready(m_ready), .m_data(md1), .m_overflow(mo1)
    );

    wide_mac_stream #(.A_WIDTH(8), .B_WIDTH(8), .ACC_WIDTH(16), .SATURATE(1)) dut2 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(ready2), .s_a(s_a8), .s_b(s_b8),
        .s_last(s_last), .m_valid(mv2), .m_ready(m_ready), .m_data(md2), .m_overflow(mo2)
    );

    wide_mac_stream #(.A_WIDTH(8), .B_WIDTH(8), .ACC_WIDTH(16), .SATURATE(0)) dut3 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(ready3), .s_a(s_a8), .s_b(s_b8),
        .s_last(s_last), .m_valid(mv3), .m_ready(m_ready), .m_data(md3), .m_overflow(mo3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string           name;
        int              sel;
        int              n;
        logic [2:0][33:0] a;
        logic [2:0][33:0] b;
        logic [63:0]     exp;
        logic            ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input logic v, input logic [33:0] a, input logic [33:0] b, input logic l);
        s_valid = v;
        s_a24   = a[23:0];
        s_b34   = b;
        s_a8    = a[7:0];
        s_b8    = b[7:0];
        s_last  = l;
    endtask

    task automatic add(input string name, input int sel, input int n,
                       input logic [33:0] a0, input logic [33:0] b0,
                       input logic [33:0] a1, input logic [33:0] b1,
                       input logic [33:0] a2, input logic [33:0] b2,
                       input logic [63:0] exp, input logic ovf);
        vec_t v;
        v.name = name; v.sel = sel; v.n = n;
        v.a[0] = a0; v.b[0] = b0; v.a[1] = a1; v.b[1] = b1; v.a[2] = a2; v.b[2] = b2;
        v.exp = exp; v.ovf = ovf;
        vecs.push_back(v);
    endtask

    function automatic logic sel_mv(input int sel);
        case (sel)
            0:       return mv0;
            1:       return mv1;
            2:       return mv2;
            default: return mv3;
        endcase
    endfunction

    function automatic logic [63:0] sel_md(input int sel);
        case (sel)
            0:       return md0;
            1:       return md1;
            2:       return {48'b0, md2};
            default: return {48'b0, md3};
        endcase
    endfunction

    function automatic logic sel_mo(input int sel);
        case (sel)
            0:       return mo0;
            1:       return mo1;
            2:       return mo2;
            default: return mo3;
        endcase
    endfunction

    // Idles the input and waits (bounded) until the chosen instance presents a result.
    task automatic wait_mv(input int sel, output bit got);
        got = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            drive(1'b0, '0, '0, 1'b0);
            #1;
            if (sel_mv(sel)) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        bit seen;
        bit acc_prev;
        int idx;
        int exp_idx;

        rst = 1'b1;
        m_ready = 1'b1;
        drive(1'b0, '0, '0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_m_valid", mv0, 0);
        check("reset_m_data", md0, 0);
        check("reset_m_overflow", mo0, 0);
        check("reset_s_ready", ready0, 1);

        // Three-beat group: exact latency and single-cycle m_valid
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            case (t)
                0:       drive(1'b1, 34'd2, 34'd3, 1'b0);
                1:       drive(1'b1, 34'd4, 34'd5, 1'b0);
                2:       drive(1'b1, 34'd6, 34'd7, 1'b1);
                default: drive(1'b0, '0, '0, 1'b0);
            endcase
            #1;
            if (t >= 1) check($sformatf("latency_valid_c%0d", t - 1), mv0, (t == 8) ? 1 : 0);
            if (t == 8) begin
                check("latency_data", md0, 64'd68);
                check("latency_ovf", mo0, 0);
            end
        end

        add("sum3",        0, 3, 2, 3, 4, 5, 6, 7, 64'd68, 1'b0);
        add("signed_neg",  1, 1, 34'hFFFFFD, 5, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
        add("sat_over",    2, 2, 200, 200, 200, 200, 0, 0, 64'd65535, 1'b1);
        add("sat_next",    2, 1, 1, 1, 0, 0, 0, 0, 64'd1, 1'b0);
        add("wrap_over",   3, 2, 200, 200, 200, 200, 0, 0, 64'd14464, 1'b1);
        add("wrap_next",   3, 1, 1, 1, 0, 0, 0, 0, 64'd1, 1'b0);
        add("umax_prod",   0, 1, 34'hFFFFFF, 34'h3_FFFF_FFFF, 0, 0, 0, 0, 64'h03FF_FFFB_FF00_0001, 1'b0);
        add("smin_prod",   1, 1, 34'h800000, 2, 0, 0, 0, 0, 64'hFFFF_FFFF_FF00_0000, 1'b0);
        add("sat_edge",    2, 2, 255, 255, 255, 2, 0, 0, 64'd65535, 1'b0);
        add("wrap_edge",   3, 3, 255, 255, 255, 2, 1, 1, 64'd0, 1'b1);
        add("sat_hold",    2, 3, 200, 200, 200, 200, 1, 1, 64'd65535, 1'b1);
        add("signed_mix",  1, 3, 34'hFFFFFF, 10, 2, 3, 34'hFFFFFE, 1, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0);

        foreach (vecs[k]) begin
            for (int j = 0; j < vecs[k].n; j++) begin
                @(negedge clk);
                drive(1'b1, vecs[k].a[j], vecs[k].b[j], (j == vecs[k].n - 1));
            end
            wait_mv(vecs[k].sel, got);
            check({vecs[k].name, "_arrived"}, got, 1);
            if (got) begin
                check({vecs[k].name, "_data"}, sel_md(vecs[k].sel), vecs[k].exp);
                check({vecs[k].name, "_ovf"}, sel_mo(vecs[k].sel), vecs[k].ovf);
            end
        end

        // Twenty single-beat groups with the sink stalled for cycles 3..12
        idx = 0;
        exp_idx = 0;
        acc_prev = 1'b0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (acc_prev) idx++;
            m_ready = !(t >= 3 && t <= 12);
            drive(idx < 20, 34'(idx), 34'd1, 1'b1);
            #1;
            acc_prev = s_valid && ready0;
            if (mv0) begin
                if (m_ready) begin
                    check($sformatf("stall_data_%0d", exp_idx), md0, 64'(exp_idx));
                    exp_idx++;
                end else begin
                    check($sformatf("stall_hold_c%0d", t), md0, 64'(exp_idx));
                    check($sformatf("stall_ready_c%0d", t), ready0, 0);
                end
            end
        end
        check("stall_result_count", 64'(exp_idx), 64'd20);
        check("stall_beats_sent", 64'(idx), 64'd20);
        m_ready = 1'b1;
        drive(1'b0, '0, '0, 1'b0);
        repeat (10) @(negedge clk);

        // Back-to-back single-beat groups at full rate
        for (int t = 0; t < 18; t++) begin
            @(negedge clk);
            if (t < 10) drive(1'b1, 34'(100 + t), 34'd1, 1'b1);
            else        drive(1'b0, '0, '0, 1'b0);
            #1;
            if (t >= 1) check($sformatf("rate_valid_c%0d", t - 1), mv0, (t >= 6 && t <= 15) ? 1 : 0);
            if (t >= 6 && t <= 15) check($sformatf("rate_data_c%0d", t - 1), md0, 64'(100 + t - 6));
        end

        // Reset in the middle of a group discards the partial sum
        @(negedge clk); drive(1'b1, 34'd5, 34'd5, 1'b0);
        @(negedge clk); drive(1'b1, 34'd6, 34'd6, 1'b0);
        @(negedge clk); drive(1'b0, '0, '0, 1'b0); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #1;
        check("rst_ready", ready0, 1);
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (mv0) seen = 1'b1;
        end
        check("rst_no_result", seen, 0);
        @(negedge clk); drive(1'b1, 34'd3, 34'd3, 1'b1);
        wait_mv(0, got);
        check("rst_next_arrived", got, 1);
        if (got) begin
            check("rst_next_data", md0, 64'd9);
            check("rst_next_ovf", mo0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
